tile_cfg_ctrl: RTL
==================

Name: tile_cfg_ctrl

Overview:
Parametrised configuration-bus endpoint and daisy-chain stage for CGRA tiles (PE, MemCore, IO).
- Decodes tile-addressed config reads and writes into a bank of NUM_REGS configuration registers.
- Forwards the config, stall and reset buses to the next tile with optional pipelining.
- Merges local read-back into the read_config_data chain.
- Successor to the fixed per-tile config logic: adds configurable register count and width, broadcast writes, multi-domain stall, and per-register update strobes.

Parameters:
ADDR_W, 32, config address width
DATA_W, 32, config data width
TILE_ID_W, 16, width of the tile-id field, at addr[TILE_ID_W-1:0]
REG_IDX_W, 8, width of the register-index field, at addr[TILE_ID_W +: REG_IDX_W]
NUM_REGS, 8, implemented config registers (1..2^REG_IDX_W)
STALL_W, 1, number of independent stall domains
PIPE_OUT, 1, 1 = registered config/stall pass-through, 0 = combinational

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
tile_id  in  TILE_ID_W  this tile's id, static after reset
config_config_addr  in  ADDR_W  incoming config address
config_config_data  in  DATA_W  incoming config write data
config_read  in  1  read request
config_write  in  1  write request
config_out_config_addr  out  ADDR_W  forwarded address
config_out_config_data  out  DATA_W  forwarded data
config_out_read  out  1  forwarded read
config_out_write  out  1  forwarded write
read_config_data_in  in  DATA_W  read chain from downstream tile
read_config_data  out  DATA_W  read chain to upstream tile
stall  in  STALL_W  per-domain stall
stall_out  out  STALL_W  forwarded stall
reset_out  out  1  forwarded reset
cfg_regs  out  NUM_REGS*DATA_W  flattened register bank, reg i at [i*DATA_W +: DATA_W]
cfg_update  out  NUM_REGS  one-cycle pulse per register written
cfg_err  out  1  sticky protocol error

Behaviour:
Reset:
- Reset is asynchronous and active-high. All registers clear to 0: cfg_regs, cfg_update, cfg_err, read-back register, pass-through pipeline.
- reset_out = reset, combinational, so the chain resets together.

Decode:
- tile_hit = addr[TILE_ID_W-1:0] == tile_id.
- bcast = tile field all ones. Broadcast applies to writes only; a broadcast read is not a hit.
- idx = register-index field. idx >= NUM_REGS is out of range.

Write:
- A write applies when config_write=1, (tile_hit or bcast) and idx is in range.
- reg[idx] <= config_config_data at that edge. cfg_update[idx] pulses high in the following cycle. Register value and pulse are visible together, one cycle after the request.
- An out-of-range write changes no register and sets cfg_err.
- Writes are accepted regardless of stall.

Read:
- rd_q <= (config_read && tile_hit && idx in range) ? reg[idx] : 0 on every cycle.
- read_config_data = rd_q | read_config_data_in, combinational OR.
- Latency is 1 cycle from request to local contribution.
- A read hit on an out-of-range idx returns 0 and sets cfg_err.

Simultaneous read and write to this tile:
- The write is performed.
- rd_q = 0.
- cfg_err is set.

Back-to-back writes:
- Writes to the same idx in consecutive cycles are each applied. The last write wins, and cfg_update pulses in both cycles.

Pass-through:
- PIPE_OUT=1: config_out_*, stall_out are registered one cycle. The tile is not a source of bubbles; every input cycle appears on the output.
- PIPE_OUT=0: pure wires.

cfg_err:
- Sticky; cleared only by reset.

Optional Feature:
Macro CFG_PARITY_EN.
- Enabled: each register stores an extra even-parity bit computed from the written data.
- A continuous checker compares stored parity against the stored data for all NUM_REGS registers.
- Any mismatch sets cfg_err. The mismatch covers SEU-style corruption; the bench injects it via force.
- Read-back data is unchanged.
- Disabled: no parity storage; cfg_err covers protocol errors only.

Decomposition:
Package tile_cfg_pkg holds:
- the address-field functions get_tile_id and get_reg_idx
- the broadcast-id constant
- the default widths

One sub-module, tile_cfg_pipe: a parametrised PIPE_OUT register stage reused for the config and stall pass-through. The register bank and decode stay in the top module.

Test Plan:
- Reset mid-operation: assert reset while config_write=1 → all cfg_regs=0, cfg_update=0, outputs clear immediately without a clock edge.
- Local write then read: tile_id=0x0005; write addr=0x0003_0005, data=0xDEADBEEF → cfg_regs[3]=0xDEADBEEF and cfg_update=8'b0000_1000 next cycle; read same addr → read_config_data=0xDEADBEEF one cycle later.
- Broadcast and miss: write addr=0x0001_FFFF, data=0x12 → reg1=0x12. Write addr=0x0001_0006, data=0x34 → no change, but config_out_write=1 with addr 0x0001_0006 one cycle later.
- Read-chain merge: read_config_data_in=0x0000_F000, local read of reg holding 0x0000_000F → read_config_data=0x0000_F00F. Read of another tile → read_config_data=0x0000_F000.
- Errors: write idx=9 with NUM_REGS=8 → no reg change, cfg_err=1. Same-cycle read+write to reg2 with data 0x55 → reg2=0x55, rd_q=0, cfg_err remains 1 until reset.
- Stall forwarding: STALL_W=2, stall=2'b10 → stall_out=2'b10 one cycle later with PIPE_OUT=1, same cycle with PIPE_OUT=0. A write issued during stall is still applied.

Source files
------------

// File: rtl/tile_cfg_pkg.sv
// Shared field-extraction helpers, broadcast id and default widths for the
// tile configuration endpoint.
package tile_cfg_pkg;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_TILE_ID_W = 16;
  localparam int DEF_REG_IDX_W = 8;
  localparam int DEF_NUM_REGS  = 8;
  localparam int DEF_STALL_W   = 1;

  // Helpers work on a wide container; callers zero-extend and truncate.
  localparam int FIELD_W = 64;

  // All-ones tile field addresses every tile (writes only).
  localparam logic [FIELD_W-1:0] BCAST_ID = '1;

  function automatic logic [FIELD_W-1:0] get_tile_id(input logic [FIELD_W-1:0] addr,
                                                     input int tile_w);
    logic [FIELD_W-1:0] mask;
    mask = ~({FIELD_W{1'b1}} << tile_w);
    return addr & mask;
  endfunction

  function automatic logic [FIELD_W-1:0] get_reg_idx(input logic [FIELD_W-1:0] addr,
                                                     input int tile_w,
                                                     input int idx_w);
    logic [FIELD_W-1:0] mask;
    mask = ~({FIELD_W{1'b1}} << idx_w);
    return (addr >> tile_w) & mask;
  endfunction

endpackage

// File: rtl/tile_cfg_pipe.sv
// Optional one-cycle register stage used for the config and stall
// pass-through to the next tile in the chain.
module tile_cfg_pipe #(
  parameter int W    = 1,
  parameter int PIPE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (PIPE != 0) begin : g_reg
      logic [W-1:0] data_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) data_q <= '0;
        else     data_q <= d_i;
      end
      assign q_o = data_q;
    end else begin : g_wire
      assign q_o = d_i;
    end
  endgenerate

endmodule

// File: rtl/tile_cfg_ctrl.sv
// Config-bus endpoint and daisy-chain stage for a CGRA tile: register bank,
// read-back merge and forwarded buses. Optional CFG_PARITY_EN adds parity checking.
module tile_cfg_ctrl
  import tile_cfg_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TILE_ID_W = DEF_TILE_ID_W,
  parameter int REG_IDX_W = DEF_REG_IDX_W,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int STALL_W   = DEF_STALL_W,
  parameter int PIPE_OUT  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [TILE_ID_W-1:0]       tile_id,
  input  logic [ADDR_W-1:0]          config_config_addr,
  input  logic [DATA_W-1:0]          config_config_data,
  input  logic                       config_read,
  input  logic                       config_write,
  output logic [ADDR_W-1:0]          config_out_config_addr,
  output logic [DATA_W-1:0]          config_out_config_data,
  output logic                       config_out_read,
  output logic                       config_out_write,
  input  logic [DATA_W-1:0]          read_config_data_in,
  output logic [DATA_W-1:0]          read_config_data,
  input  logic [STALL_W-1:0]         stall,
  output logic [STALL_W-1:0]         stall_out,
  output logic                       reset_out,
  output logic [NUM_REGS*DATA_W-1:0] cfg_regs,
  output logic [NUM_REGS-1:0]        cfg_update,
  output logic                       cfg_err
);

  localparam int CFG_W = ADDR_W + DATA_W + 2;

  // The config bus has no ready: every request is taken in the cycle it is
  // presented, independent of stall, and the chain never back-pressures.
  logic [TILE_ID_W-1:0] tile_f;
  logic [REG_IDX_W-1:0] idx;
  logic                 tile_hit, bcast, idx_ok;
  logic                 wr_apply, wr_oor, rd_oor, conflict;
  logic                 par_err;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             upd_q, upd_d;
  logic [DATA_W-1:0]               rd_q, rd_d, rd_val;
  logic                            err_q, err_d;

  assign tile_f   = TILE_ID_W'(get_tile_id(FIELD_W'(config_config_addr), TILE_ID_W));
  assign idx      = REG_IDX_W'(get_reg_idx(FIELD_W'(config_config_addr), TILE_ID_W, REG_IDX_W));
  assign tile_hit = (tile_f == tile_id);
  assign bcast    = (tile_f == TILE_ID_W'(BCAST_ID));
  assign idx_ok   = (32'(idx) < NUM_REGS);

  assign wr_apply = config_write && (tile_hit || bcast) && idx_ok;
  assign wr_oor   = config_write && (tile_hit || bcast) && !idx_ok;
  assign rd_oor   = config_read && tile_hit && !idx_ok;
  // A read hit implies the shared address also hits for the write.
  assign conflict = config_read && tile_hit && config_write;

  always_comb begin
    regs_d = regs_q;
    upd_d  = '0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(idx) == i) begin
        rd_val = regs_q[i];
        if (wr_apply) begin
          regs_d[i] = config_config_data;
          upd_d[i]  = 1'b1;
        end
      end
    end
    rd_d  = (config_read && tile_hit && idx_ok && !conflict) ? rd_val : '0;
    err_d = err_q | wr_oor | rd_oor | conflict | par_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
      upd_q  <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      upd_q  <= upd_d;
      rd_q   <= rd_d;
      err_q  <= err_d;
    end
  end

`ifdef CFG_PARITY_EN
  logic [NUM_REGS-1:0] par_q, par_d, par_bad;

  // Even parity per register; reset state (all zero) is self-consistent.
  always_comb begin
    par_d = par_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (upd_d[i]) par_d[i] = ^config_config_data;
      par_bad[i] = (^regs_q[i]) != par_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_q <= '0;
    else       par_q <= par_d;
  end

  assign par_err = |par_bad;
`else
  assign par_err = 1'b0;
`endif

  tile_cfg_pipe #(.W(CFG_W), .PIPE(PIPE_OUT)) u_cfg_pipe (
    .clk (clk),
    .rst (reset),
    .d_i ({config_config_addr, config_config_data, config_read, config_write}),
    .q_o ({config_out_config_addr, config_out_config_data, config_out_read, config_out_write})
  );

  tile_cfg_pipe #(.W(STALL_W), .PIPE(PIPE_OUT)) u_stall_pipe (
    .clk (clk),
    .rst (reset),
    .d_i (stall),
    .q_o (stall_out)
  );

  assign reset_out        = reset;
  assign read_config_data = rd_q | read_config_data_in;
  assign cfg_regs         = regs_q;
  assign cfg_update       = upd_q;
  assign cfg_err          = err_q;

endmodule
